// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings, state enum and sizing for ex_muldiv
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int WIDTH_DEFAULT = 32;

  // Iteration counter must hold values up to WIDTH
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/muldiv_sign_adj.sv
// rtl/muldiv_sign_adj.sv - conditional two's-complement negate
module muldiv_sign_adj #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  // Pass through, or negate when requested
  assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO; MULDIV_EARLY_OUT_EN enables multiply early exit
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Multiply: acc = running product, mcand = shifted multiplicand.
  // Divide:   acc = {remainder, quotient/dividend}, mcand[W-1:0] = divisor.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 is_div_q, is_div_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic                 accept, op_div, op_signed, sa_in, sb_in, div_by_zero;
  logic                 skip_calc, mul_early, last_step;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   mul_sum, prod_fix;
  logic [WIDTH:0]       r_sh;
  logic                 r_ge;
  logic [WIDTH-1:0]     r_sub, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   div_next;

  assign op_div      = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed   = (op == OP_MULT) || (op == OP_DIV);
  assign sa_in       = op_signed & rs_data[WIDTH-1];
  assign sb_in       = op_signed & rt_data[WIDTH-1];
  assign div_by_zero = op_div & (rt_data == '0);
  assign accept      = (state_q == IDLE) & start & ~flush;

`ifdef MULDIV_EARLY_OUT_EN
  assign skip_calc = div_by_zero | (~op_div & (rt_data == '0));
  assign mul_early = ~is_div_q & (mplier_q[WIDTH-1:1] == '0);
`else
  assign skip_calc = div_by_zero;
  assign mul_early = 1'b0;
`endif

  assign last_step = (cnt_q == LAST) | mul_early;

  muldiv_sign_adj #(.W(WIDTH)) u_mag_a (.val_i(rs_data), .neg_i(sa_in), .res_o(mag_a));
  muldiv_sign_adj #(.W(WIDTH)) u_mag_b (.val_i(rt_data), .neg_i(sb_in), .res_o(mag_b));

  muldiv_sign_adj #(.W(2*WIDTH)) u_fix_prod (
    .val_i(acc_q), .neg_i(~is_div_q & (sa_q ^ sb_q)), .res_o(prod_fix)
  );
  muldiv_sign_adj #(.W(WIDTH)) u_fix_quo (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(sa_q ^ sb_q), .res_o(quo_fix)
  );
  muldiv_sign_adj #(.W(WIDTH)) u_fix_rem (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sa_q), .res_o(rem_fix)
  );

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    r_sh     = acc_q[2*WIDTH-1:WIDTH-1];
    r_ge     = r_sh >= {1'b0, mcand_q[WIDTH-1:0]};
    r_sub    = r_sh[WIDTH-1:0] - mcand_q[WIDTH-1:0];
    div_next = r_ge ? {r_sub, acc_q[WIDTH-2:0], 1'b1}
                    : {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush aborts CALC/FIX and blocks a start in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = skip_calc ? FIX : CALC;
      CALC: begin
        if (flush)          state_d = IDLE;
        else if (last_step) state_d = FIX;
      end
      FIX:  state_d = flush ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs; stall drops in DONE so the pipeline advances with done
  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    stall = accept | (state_q == CALC) | (state_q == FIX);
  end

  // Datapath next state: load at accept, iterate in CALC, commit HI/LO in FIX
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept) begin
      cnt_d    = '0;
      is_div_d = op_div;
      sa_d     = sa_in;
      sb_d     = sb_in;
      div0_d   = div_by_zero;
      if (div_by_zero) begin
        acc_d    = {rs_data, {WIDTH{1'b1}}};
        mcand_d  = '0;
        mplier_d = '0;
      end else if (op_div) begin
        acc_d    = {{WIDTH{1'b0}}, mag_a};
        mcand_d  = {{WIDTH{1'b0}}, mag_b};
        mplier_d = '0;
      end else begin
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, mag_a};
        mplier_d = mag_b;
      end
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q) begin
        acc_d = div_next;
      end else begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end else if (state_q == FIX && !flush) begin
      if (div0_q) begin
        hi_d = acc_q[2*WIDTH-1:WIDTH];
        lo_d = acc_q[WIDTH-1:0];
      end else if (is_div_q) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic        flush;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          t0;
    int          n;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   stall_cnt;
  int   n_checks;
  int   n_fail;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected CALC iteration count for a request
  function automatic int exp_n(input logic [1:0] o, input logic [31:0] b);
    int n;
    logic [31:0] mag;
    if (o[1]) return (b == 32'd0) ? 0 : 32;
`ifdef MULDIV_EARLY_OUT_EN
    mag = (o == OP_MULT && b[31]) ? -b : b;
    n = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    return n;
`else
    mag = b;
    n = 32;
    return n + 0 * int'(mag[0]);
`endif
  endfunction

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    @(posedge clk); #1;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    e.hi = ehi; e.lo = elo; e.t0 = cyc; e.n = exp_n(o, b);
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_t1", {63'd0, busy}, 64'd1);
    wait_idle();
  endtask

  // Monitor: pops the scoreboard whenever done is presented
  initial begin
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0;
      end else begin
        if (stall) stall_cnt++;
        else if (!busy) stall_cnt = 0;
        if (done) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("hi", {32'd0, hi}, {32'd0, e.hi});
            chk("lo", {32'd0, lo}, {32'd0, e.lo});
            chk("done_cycle", 64'(cyc), 64'(e.t0 + 2 + e.n));
            chk("stall_cycles", 64'(stall_cnt), 64'(e.n + 2));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
    rs_data = '0; rt_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op(OP_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    do_op(OP_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF);
    do_op(OP_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF);
    do_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);

    // Flush at T+5 of MULTU 3x5
    @(posedge clk); #1;
    op = OP_MULTU; rs_data = 32'd3; rt_data = 32'd5; start = 1'b1;
    t0 = cyc;
`ifdef MULDIV_EARLY_OUT_EN
    exp_q.push_back('{hi: 32'd0, lo: 32'd15, t0: t0, n: 3});
`endif
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
`ifdef MULDIV_EARLY_OUT_EN
    chk("flush_hi", {32'd0, hi}, 64'd0);
    chk("flush_lo", {32'd0, lo}, 64'd15);
`else
    chk("flush_hi", {32'd0, hi}, 64'd2);
    chk("flush_lo", {32'd0, lo}, 64'd14);
`endif

    do_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

    // Flush beats start in IDLE
    @(posedge clk); #1;
    op = OP_MULTU; rs_data = 32'd9; rt_data = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_prio_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_prio_busy", {63'd0, busy}, 64'd0);

    // Reset mid-CALC at T+10
    @(posedge clk); #1;
    op = OP_MULTU; rs_data = 32'h0001_0001; rt_data = 32'h0000_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk); #1;
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_stall", {63'd0, stall}, 64'd0);
    chk("mid_rst_hi", {32'd0, hi}, 64'd0);
    chk("mid_rst_lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
